// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes and FSM states.
package hilo_muldiv_pkg;

    localparam int HL_WIDTH = 32;

    typedef enum logic [2:0] {
        HL_MTHI  = 3'd0,
        HL_MTLO  = 3'd1,
        HL_MULT  = 3'd2,
        HL_MULTU = 3'd3,
        HL_DIV   = 3'd4,
        HL_DIVU  = 3'd5
    } hl_op_e;

    typedef enum logic [1:0] {
        HL_IDLE = 2'd0,
        HL_RUN  = 2'd1,
        HL_DONE = 2'd2
    } hl_state_e;

endpackage

// File: rtl/hilo_muldiv_div_radix2.sv
// Radix-2 restoring divider on unsigned magnitudes, one quotient bit per cycle.
// The quotient register doubles as the dividend shift register.
module hilo_muldiv_div_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;

    // One restoring step per busy cycle; abort wins over start.
    always_comb begin
        rem_shift = {rem_q, quot_q[WIDTH-1]};
        diff      = rem_shift - {1'b0, dvsr_q};
        done      = busy_q && (cnt_q == LAST);
        quot_d    = quot_q;
        rem_d     = rem_q;
        dvsr_d    = dvsr_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        if (abort) begin
            busy_d = 1'b0;
        end else if (start) begin
            quot_d = dividend;
            rem_d  = '0;
            dvsr_d = divisor;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            // A zero divisor never borrows, so the quotient fills with ones
            // and the remainder ends up holding the dividend.
            quot_d = {quot_q[WIDTH-2:0], ~diff[WIDTH]};
            rem_d  = diff[WIDTH] ? rem_shift[WIDTH-1:0] : diff[WIDTH-1:0];
            cnt_d  = cnt_q + 1'b1;
            if (done) busy_d = 1'b0;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            quot_q <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dvsr_q <= dvsr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: rtl/hilo_muldiv.sv
// Execute-stage HI/LO unit: MTHI/MTLO, single-cycle MULT/MULTU, iterative DIV/DIVU.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int WIDTH = HL_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    hl_state_e          state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               neg_q_q, neg_q_d;
    logic               neg_r_q, neg_r_d;

    logic               accept, is_div, is_sdiv, start, abort;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] mul_a, mul_b, prod;
    logic               div_busy, div_done;
    logic [WIDTH-1:0]   div_quot, div_rem, quot_fix, rem_fix;

    // Operand conditioning, multiplier and result sign fixups.
    always_comb begin
        accept   = en && !flush;
        is_sdiv  = (op == HL_DIV);
        is_div   = is_sdiv || (op == HL_DIVU);
        start    = (state_q == HL_IDLE) && accept && is_div;
        abort    = flush && (state_q != HL_IDLE);
        sign_a   = is_sdiv && a[WIDTH-1];
        sign_b   = is_sdiv && b[WIDTH-1];
        mag_a    = sign_a ? (~a + 1'b1) : a;
        mag_b    = sign_b ? (~b + 1'b1) : b;
        // Sign-extend for MULT; the low 2*WIDTH bits of the product are exact.
        mul_a    = {{WIDTH{(op == HL_MULT) && a[WIDTH-1]}}, a};
        mul_b    = {{WIDTH{(op == HL_MULT) && b[WIDTH-1]}}, b};
        prod     = mul_a * mul_b;
        quot_fix = neg_q_q ? (~div_quot + 1'b1) : div_quot;
        rem_fix  = neg_r_q ? (~div_rem + 1'b1) : div_rem;
        // Stall covers the issue cycle and every RUN cycle, but not DONE.
        stall    = start || (state_q == HL_RUN);
    end

    // Next-state logic for the divide FSM and the HI/LO registers.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        case (state_q)
            HL_IDLE: begin
                if (accept) begin
                    case (op)
                        HL_MTHI:  hi_d = a;
                        HL_MTLO:  lo_d = a;
                        HL_MULT,
                        HL_MULTU: {hi_d, lo_d} = prod;
                        HL_DIV,
                        HL_DIVU: begin
                            neg_q_d = sign_a ^ sign_b;
                            neg_r_d = sign_a;
                            state_d = HL_RUN;
                        end
                        default: ;
                    endcase
                end
            end
            HL_RUN: begin
                if (flush)         state_d = HL_IDLE;
                else if (div_done) state_d = HL_DONE;
            end
            HL_DONE: begin
                // The op still sitting in EX is the finished divide, not a new one.
                if (!flush) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end
                state_d = HL_IDLE;
            end
            default: state_d = HL_IDLE;
        endcase
    end

    // FSM, sign flags and architectural HI/LO registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= HL_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
        end
    end

    hilo_muldiv_div_radix2 #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .abort     (abort),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed testbench for hilo_muldiv with hand-computed expected values.
module tb_hilo_muldiv;

    logic        clk;
    logic        resetn;
    logic        en;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors;
    int miscompares;

    hilo_muldiv #(.WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .en     (en),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .stall  (stall),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("vec %0d %s observed=%h expected=%h", vectors, tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a divide, hold en through the stall and DONE, then check count and results.
    task automatic do_div(input string tag, input logic [2:0] dop, input logic [31:0] da,
                          input logic [31:0] db, input logic [31:0] ehi, input logic [31:0] elo);
        int cnt;
        cnt = 0;
        en = 1'b1; op = dop; a = da; b = db;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall) break;
            cnt++;
            @(posedge clk);
            #1;
        end
        chk({tag, "_stall_cycles"}, 32'(cnt), 32'd33);
        tick();
        en = 1'b0;
        chk({tag, "_hi"}, hi, ehi);
        chk({tag, "_lo"}, lo, elo);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        resetn = 1'b0; en = 1'b0; op = 3'd0; a = '0; b = '0; flush = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        #1;
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_stall", 32'(stall), 32'd0);

        // MTHI
        en = 1'b1; op = 3'd0; a = 32'h12345678;
        @(negedge clk);
        chk("mthi_stall", 32'(stall), 32'd0);
        tick();
        en = 1'b0;
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_lo", lo, 32'h0);

        // en low and ignored op code must not change anything
        en = 1'b0; op = 3'd1; a = 32'hDEADBEEF;
        tick();
        chk("en_low_lo", lo, 32'h0);
        en = 1'b1; op = 3'd6; a = 32'hDEADBEEF; b = 32'h3;
        tick();
        en = 1'b0;
        chk("op6_hi", hi, 32'h12345678);
        chk("op6_lo", lo, 32'h0);

        // MULT / MULTU
        en = 1'b1; op = 3'd2; a = 32'hFFFFFFFE; b = 32'd3;
        tick();
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFA);
        op = 3'd3;
        tick();
        en = 1'b0;
        chk("multu_hi", hi, 32'h00000002);
        chk("multu_lo", lo, 32'hFFFFFFFA);

        // Divides
        do_div("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd2, 32'd14);
        do_div("div_m7_2", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        do_div("divu_5_0", 3'd5, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
        do_div("div_min_m1", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);

        // Flush on the 10th RUN cycle
        en = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
        tick();
        en = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_stall", 32'(stall), 32'd0);
        for (int i = 0; i < 30; i++) tick();
        chk("flush_hi", hi, 32'h0);
        chk("flush_lo", lo, 32'h80000000);
        en = 1'b1; op = 3'd1; a = 32'hA5A5A5A5;
        tick();
        en = 1'b0;
        chk("mtlo_lo", lo, 32'hA5A5A5A5);
        chk("mtlo_hi", hi, 32'h0);

        // Asynchronous reset mid-divide
        en = 1'b1; op = 3'd0; a = 32'h0BADF00D;
        tick();
        en = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
        tick();
        en = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2;
        resetn = 1'b0;
        #1;
        chk("areset_hi", hi, 32'h0);
        chk("areset_lo", lo, 32'h0);
        chk("areset_stall", 32'(stall), 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        do_div("divu_9_3", 3'd5, 32'd9, 32'd3, 32'd0, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
